// File: rtl/sram_axi_bridge.sv
// SRAM-like (inst + data) to AXI bridge: one outstanding read, one outstanding write.
// Define BRIDGE_RDATA_REG_EN to register read data/data_ok one cycle after the R beat.
module sram_axi_bridge #(
    parameter logic [3:0] INST_ARID = 4'd0,
    parameter logic [3:0] DATA_ARID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} wstate_t;

    rstate_t     r_rstate;
    wstate_t     r_wstate;
    logic        r_owner_data;
    logic [31:0] r_araddr;
    logic [1:0]  r_arsize;
    logic        r_arvalid;
    logic        r_rready;
    logic [31:0] r_awaddr;
    logic [1:0]  r_awsize;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_bready;

    logic        w_data_busy;
    logic        w_data_rd_acc;
    logic        w_data_wr_acc;
    logic        w_inst_acc;
    logic        w_aw_done_nx;
    logic        w_w_done_nx;
    logic        w_rd_ok;
    logic [31:0] w_rd_word;
    logic        w_unused;

    // Instruction-port writes are serviced as reads, and only one read is ever in flight, so rid is not needed.
    assign w_unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid};

    // The data port stays blocked while any of its own transactions is open, which keeps data_ok in order.
    assign w_data_busy   = (r_rstate != R_IDLE && r_owner_data) || (r_wstate != W_IDLE);
    assign w_data_rd_acc = !reset && data_sram_req && !data_sram_wr && r_rstate == R_IDLE && !w_data_busy;
    assign w_data_wr_acc = !reset && data_sram_req && data_sram_wr && !w_data_busy;
    assign w_inst_acc    = !reset && inst_sram_req && r_rstate == R_IDLE && !w_data_rd_acc;

    assign w_aw_done_nx = r_aw_done || (r_awvalid && awready);
    assign w_w_done_nx  = r_w_done  || (r_wvalid && wready);

`ifdef BRIDGE_RDATA_REG_EN
    logic        r_rd_done;
    logic [31:0] r_rdata;
    assign w_rd_ok   = r_rd_done;
    assign w_rd_word = r_rdata;
`else
    assign w_rd_ok   = r_rready && rvalid;
    assign w_rd_word = rdata;
`endif

    assign inst_sram_addr_ok = w_inst_acc;
    assign data_sram_addr_ok = w_data_rd_acc || w_data_wr_acc;
    assign inst_sram_data_ok = w_rd_ok && !r_owner_data;
    assign data_sram_data_ok = (w_rd_ok && r_owner_data) || (r_bready && bvalid);
    assign inst_sram_rdata   = (r_rstate == R_R && !r_owner_data) ? w_rd_word : 32'd0;
    assign data_sram_rdata   = (r_rstate == R_R &&  r_owner_data) ? w_rd_word : 32'd0;

    assign arid    = r_owner_data ? DATA_ARID : INST_ARID;
    assign araddr  = r_araddr;
    assign arsize  = {1'b0, r_arsize};
    assign arvalid = r_arvalid;
    assign rready  = r_rready;
    assign awid    = DATA_ARID;
    assign awaddr  = r_awaddr;
    assign awsize  = {1'b0, r_awsize};
    assign awvalid = r_awvalid;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wvalid  = r_wvalid;
    assign bready  = r_bready;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rstate     <= R_IDLE;
            r_owner_data <= 1'b0;
            r_araddr     <= 32'd0;
            r_arsize     <= 2'd0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
`ifdef BRIDGE_RDATA_REG_EN
            r_rd_done    <= 1'b0;
            r_rdata      <= 32'd0;
`endif
        end else begin
            case (r_rstate)
                R_IDLE: if (w_data_rd_acc || w_inst_acc) begin
                    r_owner_data <= w_data_rd_acc;
                    r_araddr     <= w_data_rd_acc ? data_sram_addr : inst_sram_addr;
                    r_arsize     <= w_data_rd_acc ? data_sram_size : inst_sram_size;
                    r_arvalid    <= 1'b1;
                    r_rstate     <= R_AR;
                end
                R_AR: if (r_arvalid && arready) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_rstate  <= R_R;
                end
                R_R: begin
`ifdef BRIDGE_RDATA_REG_EN
                    // The beat is captured first; the FSM leaves R_R in the cycle that presents it.
                    if (r_rd_done) begin
                        r_rd_done <= 1'b0;
                        r_rstate  <= R_IDLE;
                    end else if (rvalid) begin
                        r_rdata   <= rdata;
                        r_rd_done <= 1'b1;
                        r_rready  <= 1'b0;
                    end
`else
                    if (rvalid) begin
                        r_rready <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
`endif
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_awaddr  <= 32'd0;
            r_awsize  <= 2'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: if (w_data_wr_acc) begin
                    r_awaddr  <= data_sram_addr;
                    r_awsize  <= data_sram_size;
                    r_wdata   <= data_sram_wdata;
                    r_wstrb   <= data_sram_wstrb;
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    r_wstate  <= W_REQ;
                end
                W_REQ: begin
                    // AW and W complete independently; B is awaited only once both have.
                    r_awvalid <= !w_aw_done_nx;
                    r_wvalid  <= !w_w_done_nx;
                    if (w_aw_done_nx && w_w_done_nx) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_wstate  <= W_B;
                    end else begin
                        r_aw_done <= w_aw_done_nx;
                        r_w_done  <= w_w_done_nx;
                    end
                end
                W_B: if (bvalid) begin
                    r_bready <= 1'b0;
                    r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: table of read transactions plus hand-written
// sequences for priority, write handshake ordering, read-after-write blocking and reset.
module tb_sram_axi_bridge;
    logic        clk;
    logic        reset;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic        bvalid, bready;

    int n_checks = 0;
    int n_errors = 0;
    int inst_acc_cnt = 0;
    int data_ok_cnt = 0;

    sram_axi_bridge dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (inst_sram_req && inst_sram_addr_ok) inst_acc_cnt++;
        if (data_sram_data_ok) data_ok_cnt++;
    end

    typedef struct {
        bit          is_data;
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        int          ar_wait;
        int          r_wait;
        logic [3:0]  exp_arid;
        logic [2:0]  exp_arsize;
    } rd_vec_t;

    rd_vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] port_ok(input bit is_data);
        return is_data ? 32'(data_sram_data_ok) : 32'(inst_sram_data_ok);
    endfunction

    function automatic logic [31:0] port_rdata(input bit is_data);
        return is_data ? data_sram_rdata : inst_sram_rdata;
    endfunction

    // Drives one request for a cycle and expects it accepted on that same cycle.
    task automatic issue(input bit is_data, input bit wr, input logic [31:0] addr, input logic [1:0] size);
        if (is_data) begin
            data_sram_req = 1'b1; data_sram_wr = wr; data_sram_addr = addr; data_sram_size = size;
        end else begin
            inst_sram_req = 1'b1; inst_sram_wr = wr; inst_sram_addr = addr; inst_sram_size = size;
        end
        #1;
        check("addr_ok on request", is_data ? 32'(data_sram_addr_ok) : 32'(inst_sram_addr_ok), 1);
        tick();
        data_sram_req = 1'b0;
        inst_sram_req = 1'b0;
    endtask

    // Entered in the first R_AR cycle; returns in the first cycle after the read completes.
    task automatic read_tail(input bit is_data, input logic [31:0] addr, input logic [2:0] exp_arsize,
                             input logic [3:0] exp_arid, input int ar_wait, input int r_wait,
                             input logic [31:0] data);
        for (int k = 0; k <= ar_wait; k++) begin
            arready = (k == ar_wait);
            #1;
            check("arvalid held", 32'(arvalid), 1);
            if (k == 0) begin
                check("araddr", araddr, addr);
                check("arid", 32'(arid), 32'(exp_arid));
                check("arsize", 32'(arsize), 32'(exp_arsize));
            end
            tick();
        end
        arready = 1'b0;
        #1;
        check("arvalid after handshake", 32'(arvalid), 0);
        check("rready in R_R", 32'(rready), 1);
        for (int k = 0; k < r_wait; k++) begin
            check("data_ok before rvalid", port_ok(is_data), 0);
            tick();
        end
        rvalid = 1'b1; rdata = data; rid = exp_arid;
        #1;
`ifdef BRIDGE_RDATA_REG_EN
        check("data_ok not in rvalid cycle", port_ok(is_data), 0);
        tick();
        rvalid = 1'b0; rdata = 32'h0BAD_F00D;
        #1;
        check("data_ok registered", port_ok(is_data), 1);
        check("rdata registered", port_rdata(is_data), data);
        check("rready off after beat", 32'(rready), 0);
        tick();
`else
        check("data_ok with rvalid", port_ok(is_data), 1);
        check("rdata passthrough", port_rdata(is_data), data);
        tick();
        rvalid = 1'b0; rdata = 32'h0BAD_F00D;
`endif
        #1;
        check("data_ok single pulse", port_ok(is_data), 0);
        check("rready idle", 32'(rready), 0);
    endtask

    initial begin
        vecs[0] = '{is_data: 1'b0, wr: 1'b0, addr: 32'h1C00_0000, size: 2'd2, data: 32'h0280_0C0C,
                    ar_wait: 0, r_wait: 0, exp_arid: 4'd0, exp_arsize: 3'd2};
        vecs[1] = '{is_data: 1'b1, wr: 1'b0, addr: 32'h1FAF_0004, size: 2'd0, data: 32'hDEAD_BEEF,
                    ar_wait: 2, r_wait: 3, exp_arid: 4'd1, exp_arsize: 3'd0};
        vecs[2] = '{is_data: 1'b0, wr: 1'b1, addr: 32'h1C00_0010, size: 2'd1, data: 32'h0000_A5A5,
                    ar_wait: 1, r_wait: 0, exp_arid: 4'd0, exp_arsize: 3'd1};
        vecs[3] = '{is_data: 1'b1, wr: 1'b0, addr: 32'h0000_0000, size: 2'd2, data: 32'hFFFF_FFFF,
                    ar_wait: 0, r_wait: 1, exp_arid: 4'd1, exp_arsize: 3'd2};

        reset = 1'b1;
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0; inst_sram_wstrb = 4'd0;
        inst_sram_addr = 32'd0; inst_sram_wdata = 32'd0;
        data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0; data_sram_wstrb = 4'd0;
        data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        tick();
        tick();

        // Reset state, with a pending inst request that must not be accepted.
        inst_sram_req = 1'b1;
        #1;
        check("reset inst addr_ok", 32'(inst_sram_addr_ok), 0);
        check("reset arvalid", 32'(arvalid), 0);
        check("reset rready", 32'(rready), 0);
        check("reset awvalid", 32'(awvalid), 0);
        check("reset wvalid", 32'(wvalid), 0);
        check("reset bready", 32'(bready), 0);
        check("reset data_ok", 32'({inst_sram_data_ok, data_sram_data_ok}), 0);
        check("reset araddr", araddr, 0);
        check("reset awaddr", awaddr, 0);
        check("reset inst rdata", inst_sram_rdata, 0);
        inst_sram_req = 1'b0;
        reset = 1'b0;
        tick();

        // No request, no acceptance and no AR traffic.
        check("idle addr_ok", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 0);
        tick();
        check("idle arvalid", 32'(arvalid), 0);

        for (int i = 0; i < 4; i++) begin
            issue(vecs[i].is_data, vecs[i].wr, vecs[i].addr, vecs[i].size);
            read_tail(vecs[i].is_data, vecs[i].addr, vecs[i].exp_arsize, vecs[i].exp_arid,
                      vecs[i].ar_wait, vecs[i].r_wait, vecs[i].data);
        end

        // Simultaneous reads: data port wins, inst waits for the data read to finish.
        inst_acc_cnt = 0;
        inst_sram_req = 1'b1; inst_sram_wr = 1'b0; inst_sram_addr = 32'h1C00_0100; inst_sram_size = 2'd2;
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h1FAF_0100; data_sram_size = 2'd2;
        #1;
        check("prio data addr_ok", 32'(data_sram_addr_ok), 1);
        check("prio inst blocked", 32'(inst_sram_addr_ok), 0);
        tick();
        data_sram_req = 1'b0;
        read_tail(1'b1, 32'h1FAF_0100, 3'd2, 4'd1, 0, 0, 32'h1111_2222);
        check("inst not accepted during data read", 32'(inst_acc_cnt), 0);
        check("inst addr_ok after data_ok", 32'(inst_sram_addr_ok), 1);
        tick();
        inst_sram_req = 1'b0;
        read_tail(1'b0, 32'h1C00_0100, 3'd2, 4'd0, 0, 0, 32'h3333_4444);
        check("inst accepted once", 32'(inst_acc_cnt), 1);

        // Write with W handshake three cycles before AW.
        data_ok_cnt = 0;
        data_sram_wdata = 32'h1234_5678; data_sram_wstrb = 4'hF;
        issue(1'b1, 1'b1, 32'h1FAF_0000, 2'd2);
        data_sram_wr = 1'b0;
        wready = 1'b1;
        #1;
        check("awvalid", 32'(awvalid), 1);
        check("wvalid", 32'(wvalid), 1);
        check("awaddr", awaddr, 32'h1FAF_0000);
        check("wdata", wdata, 32'h1234_5678);
        check("wstrb", 32'(wstrb), 32'hF);
        check("awsize", 32'(awsize), 2);
        check("awid", 32'(awid), 1);
        tick();
        wready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("wvalid dropped after W", 32'(wvalid), 0);
            check("awvalid held", 32'(awvalid), 1);
            tick();
        end
        awready = 1'b1;
        #1;
        check("bready not before AW", 32'(bready), 0);
        tick();
        awready = 1'b0;
        #1;
        check("awvalid dropped", 32'(awvalid), 0);
        check("bready in W_B", 32'(bready), 1);
        check("no data_ok before B", 32'(data_ok_cnt), 0);
        bvalid = 1'b1;
        #1;
        check("write data_ok", 32'(data_sram_data_ok), 1);
        tick();
        bvalid = 1'b0;
        #1;
        check("bready released", 32'(bready), 0);
        check("one write data_ok", 32'(data_ok_cnt), 1);

        // Write pending in W_B blocks a data read until the cycle after bvalid.
        data_sram_wdata = 32'hA5A5_0000; data_sram_wstrb = 4'h3;
        issue(1'b1, 1'b1, 32'h1FAF_0020, 2'd1);
        data_sram_wr = 1'b0;
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        #1;
        check("same-cycle AW/W reaches W_B", 32'(bready), 1);
        data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h1FAF_0040; data_sram_size = 2'd2;
        #1;
        check("RAW blocked", 32'(data_sram_addr_ok), 0);
        tick();
        check("RAW still blocked", 32'(data_sram_addr_ok), 0);
        bvalid = 1'b1;
        #1;
        check("RAW blocked in bvalid cycle", 32'(data_sram_addr_ok), 0);
        tick();
        bvalid = 1'b0;
        #1;
        check("RAW accepted after B", 32'(data_sram_addr_ok), 1);
        tick();
        data_sram_req = 1'b0;
        read_tail(1'b1, 32'h1FAF_0040, 3'd2, 4'd1, 0, 0, 32'hCAFE_0040);

        // Reset while waiting in R_R abandons the read; a late beat is ignored.
        data_ok_cnt = 0;
        issue(1'b0, 1'b0, 32'h1C00_0200, 2'd2);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1;
        check("in R_R before reset", 32'(rready), 1);
        reset = 1'b1;
        #1;
        check("reset rready", 32'(rready), 0);
        check("reset araddr mid-read", araddr, 0);
        tick();
        check("reset next cycle rready", 32'(rready), 0);
        check("reset next cycle arvalid", 32'(arvalid), 0);
        reset = 1'b0;
        rvalid = 1'b1; rdata = 32'h7777_7777;
        #1;
        check("late beat no inst data_ok", 32'(inst_sram_data_ok), 0);
        check("late beat inst rdata", inst_sram_rdata, 0);
        tick();
        rvalid = 1'b0;
        #1;
        check("late beat no data_ok after", 32'({inst_sram_data_ok, data_sram_data_ok}), 0);
        tick();
        check("no data_ok from abandoned read", 32'(data_ok_cnt), 0);

        issue(vecs[0].is_data, vecs[0].wr, vecs[0].addr, vecs[0].size);
        read_tail(vecs[0].is_data, vecs[0].addr, vecs[0].exp_arsize, vecs[0].exp_arid,
                  vecs[0].ar_wait, vecs[0].r_wait, vecs[0].data);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
